hidden_backprop_seq: RTL and testbench

Parametrised, sequential weight-update engine for one hidden neuron's input weights during backprop. It replaces the single-cycle, fixed-4-input update with a start/done handshake. Each run computes one gradient term, then walks the weight bank one index per cycle with an arithmetic-shift learning rate, per-input masking and signed saturation. It sits between the forward-pass result (`final_i`, `hidden_val_i`) and the weight store feeding the next forward pass.

---
 rtl/hidden_backprop_seq.sv | 173 +++++++++++++++++
 tb/tb_hidden_backprop_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/hidden_backprop_seq.sv
// Sequential backprop weight-update engine for one hidden neuron: computes one gradient term,
// then walks the weight bank one index per cycle with shift learning rate, masking and clamping.
module hidden_backprop_seq #(
   parameter int unsigned N_IN     = 4,
   parameter int unsigned W_W      = 8,
   parameter int unsigned F_W      = 19,
   parameter int unsigned T_W      = 4,
   parameter int unsigned H_W      = 10,
   parameter int unsigned LR_SHIFT = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  zero_weight_reset_i,
   input  logic [F_W-1:0]        final_i,
   input  logic [T_W-1:0]        target_i,
   input  logic [H_W-1:0]        hidden_val_i,
   input  logic [N_IN-1:0]       x_i,
   input  logic [N_IN*W_W-1:0]   w_i,
   output logic [N_IN*W_W-1:0]   w_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  sat_o
);

   localparam int unsigned KW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int unsigned EW = F_W + 2;
   localparam int unsigned GW = F_W + H_W + 3;
   localparam int unsigned SW = GW + 1;
   localparam int unsigned BW = N_IN * W_W;

   localparam logic signed [SW-1:0] WMax = {{(SW-W_W+1){1'b0}}, {(W_W-1){1'b1}}};
   localparam logic signed [SW-1:0] WMin = ~WMax;

   typedef enum logic [1:0] {StIdle, StCalc, StUpd, StDone} state_e;

   state_e                state_q, state_d;
   logic [F_W-1:0]        final_q, final_d;
   logic [T_W-1:0]        target_q, target_d;
   logic [H_W-1:0]        hidden_q, hidden_d;
   logic [N_IN-1:0]       x_q, x_d;
   logic [BW-1:0]         w_q, w_d;
   logic signed [GW-1:0]  g_q, g_d;
   logic [KW-1:0]         k_q, k_d;
   logic                  sat_q, sat_d;

   logic [EW-1:0]         e;
   logic [GW-1:0]         e_ext;
   logic [GW-1:0]         h_ext;
   logic signed [GW-1:0]  delta;
   logic signed [W_W-1:0] w_k;
   logic                  m_k;
   logic signed [SW-1:0]  s;
   logic [W_W-1:0]        w_clamp;
   logic                  clamp_hit;

   // Both operands zero-extended; the difference is read back as signed.
   assign e     = {{(EW-T_W){1'b0}}, target_q} - {2'b00, final_q};
   assign e_ext = {{(GW-EW){e[EW-1]}}, e};
   assign h_ext = {{(GW-H_W){1'b0}}, hidden_q};
   assign delta = g_q >>> LR_SHIFT;

   always_comb begin
      w_k = '0;
      m_k = 1'b0;
      for (int i = 0; i < int'(N_IN); i++) begin
         if (k_q == KW'(i)) begin
            w_k = w_q[i*W_W +: W_W];
            m_k = x_q[i];
         end
      end
   end

   // One extra bit over the gradient width so the sum can never wrap.
   assign s = {{(SW-W_W){w_k[W_W-1]}}, w_k} + {delta[GW-1], delta};

   always_comb begin
      clamp_hit = 1'b0;
      w_clamp   = s[W_W-1:0];
      if (s > WMax) begin
         clamp_hit = 1'b1;
         w_clamp   = WMax[W_W-1:0];
      end else if (s < WMin) begin
         clamp_hit = 1'b1;
         w_clamp   = WMin[W_W-1:0];
      end
   end

   always_comb begin
      state_d  = state_q;
      final_d  = final_q;
      target_d = target_q;
      hidden_d = hidden_q;
      x_d      = x_q;
      w_d      = w_q;
      g_d      = g_q;
      k_d      = k_q;
      sat_d    = sat_q;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               final_d  = final_i;
               target_d = target_i;
               hidden_d = hidden_val_i;
               x_d      = x_i;
               w_d      = w_i;
               sat_d    = 1'b0;
               k_d      = '0;
               state_d  = StCalc;
            end
         end
         StCalc: begin
            g_d     = e_ext * h_ext;
            state_d = StUpd;
         end
         StUpd: begin
            if (m_k) begin
               for (int i = 0; i < int'(N_IN); i++) begin
                  if (k_q == KW'(i)) w_d[i*W_W +: W_W] = w_clamp;
               end
               sat_d = sat_q | clamp_hit;
            end
            if (k_q == KW'(N_IN - 1)) begin
               k_d     = '0;
               state_d = StDone;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Zero-reset overrides any FSM activity, including a same-cycle start.
      if (zero_weight_reset_i) begin
         w_d     = '0;
         state_d = StIdle;
         k_d     = '0;
         sat_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q  <= StIdle;
         final_q  <= '0;
         target_q <= '0;
         hidden_q <= '0;
         x_q      <= '0;
         w_q      <= '0;
         g_q      <= '0;
         k_q      <= '0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         final_q  <= final_d;
         target_q <= target_d;
         hidden_q <= hidden_d;
         x_q      <= x_d;
         w_q      <= w_d;
         g_q      <= g_d;
         k_q      <= k_d;
         sat_q    <= sat_d;
      end
   end

   assign w_o    = w_q;
   assign busy_o = (state_q != StIdle);
   assign done_o = (state_q == StDone);
   assign sat_o  = sat_q;

endmodule

// File: tb/tb_hidden_backprop_seq.sv
// Scoreboard bench for hidden_backprop_seq: runs push expected {bank, sat}; a monitor pops on done_o.
module tb_hidden_backprop_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        zr = 1'b0;
   logic [18:0] fin = '0;
   logic [3:0]  tgt = '0;
   logic [9:0]  hid = '0;
   logic [3:0]  x = '0;
   logic [31:0] w_in = '0;
   logic [31:0] w_out;
   logic        busy, done, sat;

   int          n_checks = 0;
   int          n_err = 0;
   logic [32:0] sb_q[$];
   logic [32:0] exp_e;

   hidden_backprop_seq dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .start_i             (start),
      .zero_weight_reset_i (zr),
      .final_i             (fin),
      .target_i            (tgt),
      .hidden_val_i        (hid),
      .x_i                 (x),
      .w_i                 (w_in),
      .w_o                 (w_out),
      .busy_o              (busy),
      .done_o              (done),
      .sat_o               (sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst && done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", {31'b0, done}, 32'd0);
         end else begin
            exp_e = sb_q.pop_front();
            chk("w_o", w_out, exp_e[32:1]);
            chk("sat_o", {31'b0, sat}, {31'b0, exp_e[0]});
         end
      end
   end

   // Caller sits just after a posedge; that cycle is cycle 0 with start high.
   task automatic run(input logic [31:0] w, input logic [3:0] t, input logic [18:0] f,
                      input logic [9:0] h, input logic [3:0] m, input logic [31:0] exp_w,
                      input logic exp_sat, input int restart_c, input int zr_c, input int max_c);
      int done_c = 0;
      int n_done = 0;
      if (zr_c < 0) sb_q.push_back({exp_w, exp_sat});
      w_in  = w;
      tgt   = t;
      fin   = f;
      hid   = h;
      x     = m;
      start = 1'b1;
      @(posedge clk);
      #1;
      for (int c = 1; c <= max_c; c++) begin
         start = (c == restart_c);
         zr    = (c == zr_c);
         @(negedge clk);
         if (done) begin
            n_done++;
            done_c = c;
         end
         if (c == 1) begin
            chk("busy_c1", {31'b0, busy}, 32'd1);
            chk("sat_cleared_c1", {31'b0, sat}, 32'd0);
         end
         if (zr_c < 0 && c == 6) chk("busy_c6", {31'b0, busy}, 32'd1);
         if (zr_c < 0 && c == 7) chk("busy_c7", {31'b0, busy}, 32'd0);
         if (zr_c >= 0 && c == zr_c + 1) begin
            chk("abort_w_o", w_out, 32'd0);
            chk("abort_busy", {31'b0, busy}, 32'd0);
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      zr    = 1'b0;
      if (zr_c < 0) begin
         chk("done_cycle", done_c, 32'd6);
         chk("done_count", n_done, 32'd1);
      end else begin
         chk("abort_done_count", n_done, 32'd0);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_w_o", w_out, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_sat", {31'b0, sat}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Basic: delta = +1 on every weight
      run(32'h0A0A0A0A, 4'd4, 19'd2, 10'd8, 4'b1111, 32'h0B0B0B0B, 1'b0, -1, -1, 7);

      // Reset held with start high: bank cleared, no run
      rst   = 1'b0;
      start = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst2_w_o", w_out, 32'd0);
      chk("rst2_busy", {31'b0, busy}, 32'd0);
      chk("rst2_done", {31'b0, done}, 32'd0);
      chk("rst2_sat", {31'b0, sat}, 32'd0);
      @(posedge clk);
      #1;
      rst   = 1'b1;
      start = 1'b0;
      @(negedge clk);
      chk("rst2_busy_after", {31'b0, busy}, 32'd0);
      @(posedge clk);
      #1;

      // Negative saturation on w0: -120 + -625 -> -128
      run(32'h00000088, 4'd0, 19'd100, 10'd100, 4'b0001, 32'h00000080, 1'b1, -1, -1, 7);
      // Mask 0101, delta = +30
      run(32'h08070605, 4'd15, 19'd0, 10'd32, 4'b0101, 32'h08250623, 1'b0, -1, -1, 7);
      // Start re-asserted mid-run is ignored
      run(32'h0A0A0A0A, 4'd4, 19'd2, 10'd8, 4'b1111, 32'h0B0B0B0B, 1'b0, 3, -1, 7);
      // Zero-reset in cycle 3 aborts; next start lands in cycle 5
      run(32'h0A0A0A0A, 4'd4, 19'd2, 10'd8, 4'b1111, 32'h0, 1'b0, -1, 3, 4);
      run(32'h0A0A0A0A, 4'd4, 19'd2, 10'd8, 4'b1111, 32'h0B0B0B0B, 1'b0, -1, -1, 7);
      // Positive clamp on w3: 120 + 959 -> 127
      run(32'h78000000, 4'd15, 19'd0, 10'd1023, 4'b1000, 32'h7F000000, 1'b1, -1, -1, 7);
      // Following run must clear sat_o
      run(32'h0A0A0A0A, 4'd4, 19'd2, 10'd8, 4'b1111, 32'h0B0B0B0B, 1'b0, -1, -1, 7);

      repeat (2) @(posedge clk);
      chk("scoreboard_empty", sb_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
